// File: rtl/silife_max7219.sv
// silife_max7219: streams SiLife matrix rows to a MAX7219 over DIN/CLK/LOAD, with power-up config, intensity updates and shutdown.
// Word period is 33*CLK_DIV cycles (+1 FETCH cycle for row words); enable and intensity are only sampled at frame boundaries.
module silife_max7219 #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int CLK_DIV = 4,
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       intensity,
  input  logic [WIDTH-1:0] cells,
  output logic [RW-1:0]    row_select,
  output logic             spi_cs,
  output logic             spi_sck,
  output logic             spi_mosi,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {IDLE, INIT, FETCH, SHIFT, LOAD, GAP} state_t;
  typedef enum logic [1:0] {K_INIT, K_ROW, K_INTEN, K_SHDN} kind_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [15:0]   word_q, word_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [RW-1:0] row_q, row_d;
  logic [3:0]    last_int_q, last_int_d;
  logic [DW-1:0] div_q;
  logic [4:0]    half_q;
  logic          div_last, word_end;
  logic [7:0]    row_data;

  function automatic logic [15:0] init_word(input logic [2:0] p, input logic [3:0] inten);
    case (p)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = 16'h0F00;
      3'd2:    init_word = 16'h0900;
      3'd3:    init_word = {8'h0B, 8'(HEIGHT - 1)};
      default: init_word = {12'h0A0, inten};
    endcase
  endfunction

  assign row_data = 8'(cells) << (8 - WIDTH);
  assign div_last = (div_q == DW'(CLK_DIV - 1));
  // LOAD is the first CS-high cycle, so GAP only covers the remaining D-1 cycles.
  assign word_end = ((state_q == LOAD) && (CLK_DIV == 1)) ||
                    ((state_q == GAP) && (div_q == DW'(CLK_DIV - 2)));

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    word_d     = word_q;
    ptr_d      = ptr_q;
    row_d      = row_q;
    last_int_d = last_int_q;
    case (state_q)
      IDLE:  if (enable) begin
               state_d = INIT;
               ptr_d   = '0;
             end
      INIT:  begin
               state_d = SHIFT;
               kind_d  = K_INIT;
               word_d  = init_word(ptr_q, intensity);
               if (ptr_q == 3'd4) last_int_d = intensity;
             end
      FETCH: begin
               state_d = SHIFT;
               kind_d  = K_ROW;
               word_d  = {4'h0, 4'(row_q) + 4'd1, row_data};
             end
      SHIFT: if (half_q == 5'd31 && div_last) state_d = LOAD;
      LOAD:  if (CLK_DIV > 1) state_d = GAP;
      default: ;
    endcase
    if (word_end) begin
      state_d = FETCH;
      row_d   = '0;
      case (kind_q)
        K_INIT: if (ptr_q != 3'd4) begin
                  ptr_d   = ptr_q + 3'd1;
                  state_d = SHIFT;
                  word_d  = init_word(ptr_q + 3'd1, intensity);
                  if (ptr_q == 3'd3) last_int_d = intensity;
                end else if (!enable) begin
                  state_d = SHIFT;
                  kind_d  = K_SHDN;
                  word_d  = 16'h0C00;
                end
        K_ROW:  if (row_q != LAST_ROW) begin
                  row_d = row_q + 1'b1;
                end else if (!enable) begin
                  state_d = SHIFT;
                  kind_d  = K_SHDN;
                  word_d  = 16'h0C00;
                end else if (intensity != last_int_q) begin
                  state_d    = SHIFT;
                  kind_d     = K_INTEN;
                  word_d     = {12'h0A0, intensity};
                  last_int_d = intensity;
                end
        K_INTEN: ;
        K_SHDN:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      kind_q     <= K_INIT;
      word_q     <= '0;
      ptr_q      <= '0;
      row_q      <= '0;
      last_int_q <= '0;
      div_q      <= '0;
      half_q     <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      word_q     <= word_d;
      ptr_q      <= ptr_d;
      row_q      <= row_d;
      last_int_q <= last_int_d;
      // half_q counts SCK half-periods; its LSB is the serial clock level.
      if (state_d != state_q) begin
        div_q  <= '0;
        half_q <= '0;
      end else if (state_q == SHIFT) begin
        if (div_last) begin
          div_q  <= '0;
          half_q <= half_q + 5'd1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end else if (state_q == GAP) begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign spi_cs     = (state_q != SHIFT);
  assign spi_sck    = (state_q == SHIFT) && half_q[0];
  assign spi_mosi   = (state_q == SHIFT) && word_q[~half_q[4:1]];
  assign row_select = row_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == LOAD) && (kind_q == K_ROW) && (row_q == LAST_ROW);

endmodule
